// File: rtl/fifo_uart_tx.sv
// FIFO-fed 8N1 UART transmitter: pops one byte per frame from a sync FIFO with
// 1-cycle read latency and shifts it out on tx, start bit first, data LSB-first.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] BIT_LAST = 3'd7;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;

  state_t            state, state_nxt;
  logic [BAUD_W-1:0] baud_cnt, baud_nxt;
  logic [2:0]        bit_cnt, bit_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic              rd_en_nxt, tx_nxt, busy_nxt, done_nxt;
  logic              baud_wrap, can_start;

  assign baud_wrap = (baud_cnt == BAUD_LAST);
  assign can_start = enable && !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      fifo_rd_en <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      baud_cnt   <= baud_nxt;
      bit_cnt    <= bit_nxt;
      shreg      <= shreg_nxt;
      fifo_rd_en <= rd_en_nxt;
      tx         <= tx_nxt;
      busy       <= busy_nxt;
      frame_done <= done_nxt;
    end
  end

  // Outputs are decoded from the next state so the registered copies line up
  // with the state they describe rather than trailing it by a cycle.
  always_comb begin
    state_nxt = state;
    baud_nxt  = '0;
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;

    case (state)
      IDLE: begin
        bit_nxt = '0;
        if (can_start) state_nxt = FETCH;
      end
      FETCH: state_nxt = LOAD;
      LOAD: begin
        shreg_nxt = fifo_data;
        state_nxt = START;
      end
      START: begin
        baud_nxt = baud_wrap ? '0 : baud_cnt + 1'b1;
        if (baud_wrap) begin
          bit_nxt   = '0;
          state_nxt = DATA;
        end
      end
      DATA: begin
        baud_nxt = baud_wrap ? '0 : baud_cnt + 1'b1;
        if (baud_wrap) begin
          shreg_nxt = shreg >> 1;
          bit_nxt   = bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) state_nxt = STOP;
        end
      end
      STOP: begin
        baud_nxt = baud_wrap ? '0 : baud_cnt + 1'b1;
        if (baud_wrap) state_nxt = can_start ? FETCH : IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    rd_en_nxt = (state_nxt == FETCH);
    busy_nxt  = (state_nxt != IDLE);
    done_nxt  = (state_nxt == STOP) && (baud_nxt == BAUD_LAST);

    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shreg_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: behavioural FIFO, a tx frame decoder/monitor, and a
// byte scoreboard checked against hand-computed vectors and random traffic.
module tb_fifo_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd_en, tx, busy, frame_done;

  logic       wr_en;
  logic [7:0] wr_data;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Behavioural sync_fifo: registered data_out one cycle after rd_en.
  logic [7:0] fifo_q[$];
  int underflows = 0;
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fifo_q.size() == 0) underflows++;
      else fifo_data <= fifo_q.pop_front();
    end
    if (wr_en) fifo_q.push_back(wr_data);
    fifo_empty <= (fifo_q.size() == 0);
  end

  typedef struct {
    logic [9:0] bits;
    logic       shape_ok;
    int         latency;
    int         gap;
  } frame_rec_t;

  frame_rec_t rec [0:255];
  int   rec_wr = 0;
  int   cyc = 0, last_rd_cyc = 0, last_end_cyc = -1000, idx = 0;
  int   rd_pulses = 0, rd_while_empty = 0, fd_pulses = 0, fd_bad = 0;
  logic in_frame = 1'b0;
  logic wave [0:FRAME-1];
  logic [9:0] tmp_bits;
  logic       tmp_shape;

  // Frame decoder: a frame is the 10*CPB cycles starting where tx first goes low.
  always @(negedge clk) begin
    cyc++;
    if (fifo_rd_en) begin
      rd_pulses++;
      last_rd_cyc = cyc;
      if (fifo_empty) rd_while_empty++;
    end
    if (frame_done) fd_pulses++;
    if (rst) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame && tx == 1'b0) begin
        in_frame = 1'b1;
        idx = 0;
        rec[rec_wr].latency = cyc - last_rd_cyc;
        rec[rec_wr].gap     = cyc - last_end_cyc - 1;
      end
      if (frame_done != (in_frame && idx == FRAME - 1)) fd_bad++;
      if (in_frame) begin
        wave[idx] = tx;
        idx++;
        if (idx == FRAME) begin
          in_frame = 1'b0;
          last_end_cyc = cyc;
          tmp_shape = 1'b1;
          for (int k = 0; k < 10; k++) begin
            tmp_bits[k] = wave[k*CPB + CPB/2];
            for (int j = 0; j < CPB; j++)
              if (wave[k*CPB + j] != wave[k*CPB]) tmp_shape = 1'b0;
          end
          rec[rec_wr].bits     = tmp_bits;
          rec[rec_wr].shape_ok = tmp_shape;
          if (rec_wr < 255) rec_wr++;
        end
      end
    end
  end

  int checks = 0, errors = 0;
  int rec_rd = 0;
  logic [7:0] exp_q[$];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick(1);
    wr_en   = 1'b0;
    exp_q.push_back(b);
  endtask

  task automatic wait_tx_fall(input string name);
    int n = 0;
    while (tx !== 1'b0 && n < 20) begin
      tick(1);
      n++;
    end
    checkOutput({name, " start seen"}, 32'(tx === 1'b0), 1);
  endtask

  // Expected line image of a frame: bit i is the i-th bit on the wire.
  task automatic expect_frame(input string name, input logic use_given,
                              input logic [9:0] given, input int exp_gap);
    logic [9:0] want;
    logic [7:0] b;
    int waited = 0;
    while (rec_wr <= rec_rd && waited < 4*FRAME + 200) begin
      tick(1);
      waited++;
    end
    b = 8'h00;
    if (exp_q.size() > 0) b = exp_q.pop_front();
    if (rec_wr <= rec_rd) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: no frame within %0d cycles", name, waited);
      return;
    end
    want = use_given ? given : {1'b1, b, 1'b0};
    checkOutput({name, " bits"},    rec[rec_rd].bits, want);
    checkOutput({name, " shape"},   rec[rec_rd].shape_ok, 1);
    checkOutput({name, " latency"}, rec[rec_rd].latency, 2);
    if (exp_gap >= 0) checkOutput({name, " gap"}, rec[rec_rd].gap, exp_gap);
    rec_rd++;
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] bits;
    int         gap;
  } vec_t;
  vec_t vecs [4];

  int base_rd, low_seen;

  initial begin
    vecs[0] = '{8'h55, 10'b1010101010, -1};
    vecs[1] = '{8'hA3, 10'b1101000110, -1};
    vecs[2] = '{8'h0F, 10'b1000011110, 2};
    vecs[3] = '{8'hFF, 10'b1111111110, 2};

    rst = 1'b1; enable = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
    tick(2);
    checkOutput("reset tx", tx, 1);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset rd_en", fifo_rd_en, 0);
    checkOutput("reset frame_done", frame_done, 0);

    rst = 1'b0; enable = 1'b1;
    base_rd = rd_pulses; low_seen = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (tx !== 1'b1) low_seen++;
    end
    checkOutput("empty rd_en pulses", rd_pulses - base_rd, 0);
    checkOutput("empty tx low cycles", low_seen, 0);
    checkOutput("empty busy", busy, 0);

    base_rd = rd_pulses;
    applyStimulus(vecs[0].data);
    expect_frame("single 55", 1'b1, vecs[0].bits, vecs[0].gap);
    tick(10);
    checkOutput("single rd pulses", rd_pulses - base_rd, 1);
    checkOutput("single busy after", busy, 0);

    enable = 1'b0;
    base_rd = rd_pulses;
    for (int i = 1; i < 4; i++) applyStimulus(vecs[i].data);
    tick(5);
    checkOutput("queued no rd while disabled", rd_pulses - base_rd, 0);
    enable = 1'b1;
    for (int i = 1; i < 4; i++) expect_frame("burst", 1'b1, vecs[i].bits, vecs[i].gap);
    tick(10);
    checkOutput("burst rd pulses", rd_pulses - base_rd, 3);
    checkOutput("burst busy after", busy, 0);
    checkOutput("burst fifo empty", fifo_empty, 1);

    enable = 1'b0;
    base_rd = rd_pulses;
    applyStimulus(8'h12);
    applyStimulus(8'h34);
    applyStimulus(8'h56);
    enable = 1'b1;
    wait_tx_fall("drop");
    tick(17);
    enable = 1'b0;
    expect_frame("drop f1", 1'b0, '0, -1);
    tick(20);
    checkOutput("drop busy", busy, 0);
    checkOutput("drop tx idle", tx, 1);
    checkOutput("drop fifo not empty", fifo_empty, 0);
    checkOutput("drop rd pulses", rd_pulses - base_rd, 1);
    enable = 1'b1;
    expect_frame("drop f2", 1'b0, '0, -1);
    expect_frame("drop f3", 1'b0, '0, 2);
    tick(10);

    enable = 1'b0;
    applyStimulus(8'hC4);
    applyStimulus(8'h3B);
    enable = 1'b1;
    wait_tx_fall("abort");
    tick(25);
    rst = 1'b1;
    tick(1);
    checkOutput("abort tx", tx, 1);
    checkOutput("abort busy", busy, 0);
    checkOutput("abort rd_en", fifo_rd_en, 0);
    rst = 1'b0;
    if (exp_q.size() > 0) exp_q.delete(0);
    expect_frame("after abort", 1'b0, '0, -1);
    tick(10);

    for (int i = 0; i < 30; i++) begin
      applyStimulus(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 4) == 0) begin
        enable = 1'b0;
        tick($urandom_range(1, 60));
        enable = 1'b1;
      end else begin
        tick($urandom_range(0, 50));
      end
    end
    enable = 1'b1;
    while (exp_q.size() > 0) expect_frame("random", 1'b0, '0, -1);
    tick(20);

    checkOutput("rd_en while empty", rd_while_empty, 0);
    checkOutput("fifo underflows", underflows, 0);
    checkOutput("frame_done placement", fd_bad, 0);
    checkOutput("frame_done count", fd_pulses, rec_wr);
    checkOutput("rd_en count", rd_pulses, rec_wr + 1);
    checkOutput("final busy", busy, 0);
    checkOutput("final tx", tx, 1);
    checkOutput("final fifo empty", fifo_empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
